uart_echo_buffer: RTL and testbench
===================================

Name: uart_echo_buffer

Overview:
Buffered, mode-selectable bridge between uart_rx and uart_tx for the UART loopback top level.
- Accepts received bytes on rx-done pulses, optionally transforms them, and queues them in a parametrised FIFO.
- Drains the FIFO into uart_tx with a start/done handshake, so back-to-back RX bytes are never lost while TX is busy.
- Reports fill level and sticky overflow for ILA/debug.

Parameters:
NB_DATA, 8, data width of RX/TX bytes
FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2
NB_COUNT, $clog2(FIFO_DEPTH)+1, width of the occupancy counter (derived)

Ports:
clk  input  1  system clock
i_rst  input  1  synchronous reset, active-high
i_rx_data  input  NB_DATA  byte from uart_rx, valid while i_rx_done=1
i_rx_done  input  1  one-cycle pulse from uart_rx, byte complete
i_mode  input  2  transform select, sampled on push: 00 pass, 01 invert, 10 increment, 11 discard
i_tx_done  input  1  one-cycle pulse from uart_tx, stop bit finished
i_clr_ovf  input  1  clears o_overflow
o_tx_start  output  1  one-cycle pulse to uart_tx i_start_tx
o_tx_data  output  NB_DATA  byte to uart_tx, stable from o_tx_start until i_tx_done
o_count  output  NB_COUNT  current FIFO occupancy
o_empty  output  1  o_count==0
o_full  output  1  o_count==FIFO_DEPTH
o_overflow  output  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock, clk; reset i_rst is synchronous and active-high.
- Reset values: o_tx_start=0, o_tx_data=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, FSM=IDLE, read/write pointers=0.
- Push transform (applied at write): 00 data; 01 ~data; 10 data+1 mod 2^NB_DATA (0xFF->0x00); 11 byte discarded, no push, no overflow.
- Push accepted when i_rx_done && mode!=11 && (!o_full || pop in the same cycle).
- Push when full with no same-cycle pop:
  - Byte dropped; FIFO contents unchanged.
  - o_overflow set at the next edge.
- o_overflow clear:
  - i_clr_ovf clears it.
  - If a set and a clear happen in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH.
- o_count: +1 on push only, -1 on pop only, unchanged on simultaneous push+pop.
- TX FSM:
  - IDLE: if !o_empty, pop the head into the o_tx_data register, go to START.
  - START: o_tx_start=1 for exactly this cycle, go to WAIT.
  - WAIT: hold o_tx_data; on i_tx_done go to IDLE.
- Latency: i_rx_done in cycle 0 with FIFO empty and FSM IDLE -> entry visible in cycle 1 -> pop in cycle 1 -> o_tx_start high in cycle 2.
- Minimum gap between consecutive o_tx_start pulses is i_tx_done cycle +2.
- i_tx_done outside WAIT is ignored.
- Pop on an empty FIFO never occurs; o_count never underflows.
- Reset mid-operation:
  - FIFO is flushed and the FSM returns to IDLE.
  - A frame already started in uart_tx is not aborted by this block; its later i_tx_done is ignored.

Decomposition:
- Shared package/header uart_defs holds:
  - MODE_PASS/MODE_INV/MODE_INC/MODE_DROP encodings (2 bits).
  - FSM state encodings ST_IDLE/ST_START/ST_WAIT.
- One sub-module, sync_fifo, parametrised by NB_DATA and FIFO_DEPTH:
  - Ports: push, pop, wdata, rdata (first-word-fall-through), count, full, empty.
  - Allows simultaneous push+pop when full.
- The transform mux and TX FSM stay in uart_echo_buffer.

Test Plan:
1. Reset, mode=00, single i_rx_done with 0x41 in cycle 0 -> o_tx_start pulse in cycle 2, o_tx_data=0x41; o_count 1 then 0.
2. Five bytes 0x10..0x14 pushed back-to-back while i_tx_done is withheld -> o_count reaches 4 (the first byte is already in TX). Each following i_tx_done releases the next byte in order 0x11..0x14, then o_empty=1.
3. Modes: 0x5A with 01 -> 0xA5; 0xFF with 10 -> 0x00; 0x33 with 11 -> no o_tx_start, o_count unchanged, o_overflow=0.
4. With TX stalled, FIFO_DEPTH+2 bytes pushed -> o_full=1, o_overflow=1, extra byte dropped. Drained order matches the first FIFO_DEPTH+1 bytes. i_clr_ovf -> o_overflow=0.
5. FIFO full, i_rx_done coinciding with an IDLE pop -> push accepted, o_count stays FIFO_DEPTH, no overflow.
6. i_rst asserted in WAIT with 3 entries queued -> next cycle o_count=0, o_empty=1, o_tx_start=0. A late i_tx_done is ignored, and no o_tx_start follows until new RX data arrives.

Source files
------------

// File: rtl/uart_defs.sv
// Shared encodings for the UART echo buffer: RX transform modes and TX FSM states.
package uart_defs;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_INC  = 2'b10;
  localparam logic [1:0] MODE_DROP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
  parameter int NB_DATA    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int NB_COUNT   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                push,
  input  logic                pop,
  input  logic [NB_DATA-1:0]  wdata,
  output logic [NB_DATA-1:0]  rdata,
  output logic [NB_COUNT-1:0] count,
  output logic                full,
  output logic                empty
);

  localparam int NB_PTR = $clog2(FIFO_DEPTH);

  logic [NB_DATA-1:0]  mem [FIFO_DEPTH];
  logic [NB_PTR-1:0]   wr_ptr_reg;
  logic [NB_PTR-1:0]   rd_ptr_reg;
  logic [NB_COUNT-1:0] count_reg;
  logic                do_push;
  logic                do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == NB_COUNT'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + NB_PTR'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + NB_PTR'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + NB_COUNT'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - NB_COUNT'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffered bridge between uart_rx and uart_tx: transforms received bytes, queues
// them, and feeds uart_tx one byte per start/done handshake.
module uart_echo_buffer
  import uart_defs::*;
#(
  parameter int NB_DATA    = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int NB_COUNT   = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic [NB_DATA-1:0]  i_rx_data,
  input  logic                i_rx_done,
  input  logic [1:0]          i_mode,
  input  logic                i_tx_done,
  input  logic                i_clr_ovf,
  output logic                o_tx_start,
  output logic [NB_DATA-1:0]  o_tx_data,
  output logic [NB_COUNT-1:0] o_count,
  output logic                o_empty,
  output logic                o_full,
  output logic                o_overflow
);

  tx_state_t          state_reg;
  tx_state_t          state_next;
  logic [NB_DATA-1:0] tx_data_reg;
  logic               overflow_reg;
  logic [NB_DATA-1:0] fifo_wdata;
  logic [NB_DATA-1:0] fifo_rdata;
  logic               push_req;
  logic               fifo_pop;

  assign push_req = i_rx_done && (i_mode != MODE_DROP);

  always_comb begin
    fifo_wdata = i_rx_data;
    case (i_mode)
      MODE_INV: fifo_wdata = ~i_rx_data;
      MODE_INC: fifo_wdata = i_rx_data + NB_DATA'(1);
      default:  fifo_wdata = i_rx_data;
    endcase
  end

  sync_fifo #(
    .NB_DATA    (NB_DATA),
    .FIFO_DEPTH (FIFO_DEPTH),
    .NB_COUNT   (NB_COUNT)
  ) u_fifo (
    .clk   (clk),
    .srst  (i_rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .count (o_count),
    .full  (o_full),
    .empty (o_empty)
  );

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (!o_empty) state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (i_tx_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_tx_start = (state_reg == ST_START);
    fifo_pop   = (state_reg == ST_IDLE) && !o_empty;
  end

  // The byte is latched at pop so it stays stable for the whole frame.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      tx_data_reg <= '0;
    end else if (fifo_pop) begin
      tx_data_reg <= fifo_rdata;
    end
  end

  // A dropped byte wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      overflow_reg <= 1'b0;
    end else if (push_req && o_full && !fifo_pop) begin
      overflow_reg <= 1'b1;
    end else if (i_clr_ovf) begin
      overflow_reg <= 1'b0;
    end
  end

  assign o_tx_data  = tx_data_reg;
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Scoreboard bench for uart_echo_buffer: queue-based reference model, negedge monitor.
module tb_uart_echo_buffer;

  localparam int NB_DATA  = 8;
  localparam int DEPTH    = 16;
  localparam int NB_COUNT = $clog2(DEPTH) + 1;

  logic                clk = 1'b0;
  logic                i_rst = 1'b1;
  logic [NB_DATA-1:0]  i_rx_data = '0;
  logic                i_rx_done = 1'b0;
  logic [1:0]          i_mode = 2'b00;
  logic                i_tx_done = 1'b0;
  logic                i_clr_ovf = 1'b0;
  logic                o_tx_start;
  logic [NB_DATA-1:0]  o_tx_data;
  logic [NB_COUNT-1:0] o_count;
  logic                o_empty;
  logic                o_full;
  logic                o_overflow;

  uart_echo_buffer #(
    .NB_DATA    (NB_DATA),
    .FIFO_DEPTH (DEPTH),
    .NB_COUNT   (NB_COUNT)
  ) dut (
    .clk        (clk),
    .i_rst      (i_rst),
    .i_rx_data  (i_rx_data),
    .i_rx_done  (i_rx_done),
    .i_mode     (i_mode),
    .i_tx_done  (i_tx_done),
    .i_clr_ovf  (i_clr_ovf),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_count    (o_count),
    .o_empty    (o_empty),
    .o_full     (o_full),
    .o_overflow (o_overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int starts_seen = 0;
  bit chk_en = 1'b0;

  // Reference model: FIFO contents, whether uart_tx owns a byte, expected TX order.
  logic [7:0] m_q[$];
  logic [7:0] exp_tx[$];
  bit         m_busy = 1'b0;
  bit         m_ovf = 1'b0;
  bit         start_due = 1'b0;
  logic [7:0] cur_tx = 8'h00;

  function automatic logic [7:0] xf(input logic [7:0] d, input logic [1:0] m);
    case (m)
      2'b01:   return ~d;
      2'b10:   return 8'(d + 8'd1);
      default: return d;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (i_rst) begin
      m_q.delete();
      exp_tx.delete();
      m_busy = 1'b0;
      m_ovf = 1'b0;
      start_due = 1'b0;
    end else begin
      bit pop, live, was_full;
      pop = !m_busy && (m_q.size() > 0);
      live = i_rx_done && (i_mode != 2'b11);
      was_full = (m_q.size() == DEPTH);
      start_due = pop;
      if (i_tx_done && m_busy) m_busy = 1'b0;
      if (pop) begin
        cur_tx = m_q.pop_front();
        exp_tx.push_back(cur_tx);
        m_busy = 1'b1;
      end
      if (live && (!was_full || pop)) m_q.push_back(xf(i_rx_data, i_mode));
      if (live && was_full && !pop) m_ovf = 1'b1;
      else if (i_clr_ovf) m_ovf = 1'b0;
    end
  end

  // Monitor: compares every DUT output against the model once per cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_start", 32'(o_tx_start), 32'(start_due));
      if (o_tx_start) begin
        starts_seen++;
        if (exp_tx.size() == 0) begin
          chk("tx_unexpected", 32'(1), 32'(0));
        end else begin
          logic [7:0] e;
          e = exp_tx.pop_front();
          $display("tx byte %02h (expected %02h) at %0t", o_tx_data, e, $time);
          chk("tx_data", 32'(o_tx_data), 32'(e));
        end
      end else if (m_busy) begin
        chk("tx_hold", 32'(o_tx_data), 32'(cur_tx));
      end
      chk("count", 32'(o_count), 32'(m_q.size()));
      chk("empty", 32'(o_empty), 32'(m_q.size() == 0));
      chk("full", 32'(o_full), 32'(m_q.size() == DEPTH));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
    end
  end

  bit auto_tx = 1'b0;
  int handled = 0;
  int done_cnt = 0;
  bit armed = 1'b0;

  task automatic step(input logic rx, input logic [7:0] d, input logic [1:0] m,
                      input logic done, input logic clr, input logic rst);
    logic auto_done;
    @(negedge clk);
    #1;
    auto_done = 1'b0;
    if (!auto_tx) begin
      handled = starts_seen;
      armed = 1'b0;
    end else if (starts_seen != handled) begin
      handled = starts_seen;
      done_cnt = int'($urandom_range(1, 5));
      armed = 1'b1;
    end else if (armed) begin
      if (done_cnt <= 1) begin
        auto_done = 1'b1;
        armed = 1'b0;
      end else begin
        done_cnt--;
      end
    end
    i_rx_done = rx;
    i_rx_data = d;
    i_mode = m;
    i_tx_done = done | auto_done;
    i_clr_ovf = clr;
    i_rst = rst;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rx(input logic [7:0] d, input logic [1:0] m);
    step(1'b1, d, m, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_start();
    int s0;
    s0 = starts_seen;
    for (int k = 0; k < 100; k++) begin
      if (starts_seen != s0) return;
      idle(1);
    end
    chk("start_timeout", 32'(starts_seen), 32'(s0 + 1));
  endtask

  initial begin
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    idle(2);

    // Single byte, pass-through, latency via start_due.
    rx(8'h41, 2'b00);
    wait_start();
    idle(2);
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Back-to-back bytes with TX withheld, then released one by one.
    for (int k = 0; k < 5; k++) rx(8'(8'h10 + k), 2'b00);
    idle(3);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
      wait_start();
      idle(1);
    end
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Transform modes.
    auto_tx = 1'b1;
    rx(8'h5A, 2'b01);
    idle(12);
    rx(8'hFF, 2'b10);
    idle(12);
    rx(8'h33, 2'b11);
    idle(12);
    auto_tx = 1'b0;

    // Overflow with TX stalled, set-wins-over-clear, then clear.
    for (int k = 0; k < DEPTH + 2; k++) rx(8'(8'hA0 + k), 2'b00);
    step(1'b1, 8'hEE, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Full FIFO: push coinciding with an IDLE pop is accepted.
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    rx(8'hC3, 2'b00);
    auto_tx = 1'b1;
    idle(10 * (DEPTH + 2));
    auto_tx = 1'b0;

    // Reset while in WAIT with entries queued; a late tx_done must be ignored.
    for (int k = 0; k < 4; k++) rx(8'(8'h60 + k), 2'b00);
    idle(4);
    step(1'b0, 8'h00, 2'b00, 1'b0, 1'b0, 1'b1);
    idle(2);
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(10);
    auto_tx = 1'b1;
    rx(8'h77, 2'b00);
    idle(15);

    // Randomized traffic with a randomly paced uart_tx.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 2) == 0), 8'($urandom), 2'($urandom),
           1'b0, ($urandom_range(0, 15) == 0), 1'b0);
    end
    idle(10 * (DEPTH + 2));

    chk("drain_fifo", 32'(m_q.size()), 32'(0));
    chk("drain_tx", 32'(exp_tx.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
